// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register sitting in front of the ALU.
// - Registers the decoded operands and control every cycle.
// - Drives the ALU operands, with MEM/WB forwarding when that option is built in.
// - Flags load-use hazards back to the fetch/decode control.
// - Supports stall (hold) and flush (bubble insertion).
//
// Build option:
//   FORWARDING_EN
//     defined     : operands are forwarded from MEM, then WB; load_use_o
//                   fires only for a load in EX.
//     not defined : operands come from the registered data only; load_use_o
//                   fires for any read-after-write against EX or MEM.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   id_*                    decoded instruction from ID
//   stall_i, flush_i        hold stage / insert bubble (flush wins)
//   mem_reg_write_i, mem_rd_i, mem_result_i   EX/MEM writeback info
//   wb_reg_write_i, wb_rd_i, wb_result_i      MEM/WB writeback info
//   alu_src1_o, alu_src2_o  ALU operands
//   alu_ctrl_o              ALU op code, passed through unchanged
//   ex_store_data_o         forwarded rt value for stores
//   ex_wr_reg_o             destination register
//   ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_mem_to_reg_o
//                           registered control
//   load_use_o              hazard against the instruction currently in ID
// -----------------------------------------------------------------------------
module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs_data_i,
  input  logic [DATA_W-1:0] id_rt_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_W-1:0]  id_rs_i,
  input  logic [REG_W-1:0]  id_rt_i,
  input  logic [REG_W-1:0]  id_rd_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_dst_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_W-1:0]  mem_rd_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_W-1:0]  wb_rd_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] alu_src1_o,
  output logic [DATA_W-1:0] alu_src2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] ex_store_data_o,
  output logic [REG_W-1:0]  ex_wr_reg_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              load_use_o
);

  // Registered fields
  logic              valid_q,      valid_d;
  logic [DATA_W-1:0] rs_data_q,    rs_data_d;
  logic [DATA_W-1:0] rt_data_q,    rt_data_d;
  logic [DATA_W-1:0] imm_q,        imm_d;
  logic [REG_W-1:0]  rs_q,         rs_d;
  logic [REG_W-1:0]  rt_q,         rt_d;
  logic [REG_W-1:0]  wr_reg_q,     wr_reg_d;
  logic [CTRL_W-1:0] alu_ctrl_q,   alu_ctrl_d;
  logic              alu_src_q,    alu_src_d;
  logic              reg_write_q,  reg_write_d;
  logic              mem_read_q,   mem_read_d;
  logic              mem_write_q,  mem_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;

  // Next-state: flush > stall > capture. A capture of an invalid ID slot is
  // also a bubble, so downstream never sees stale control from an empty slot.
  always_comb begin
    valid_d      = valid_q;
    rs_data_d    = rs_data_q;
    rt_data_d    = rt_data_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    wr_reg_d     = wr_reg_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_src_d    = alu_src_q;
    reg_write_d  = reg_write_q;
    mem_read_d   = mem_read_q;
    mem_write_d  = mem_write_q;
    mem_to_reg_d = mem_to_reg_q;
    if (flush_i || (!stall_i && !id_valid_i)) begin
      valid_d      = 1'b0;
      rs_data_d    = '0;
      rt_data_d    = '0;
      imm_d        = '0;
      rs_d         = '0;
      rt_d         = '0;
      wr_reg_d     = '0;
      alu_ctrl_d   = '0;
      alu_src_d    = 1'b0;
      reg_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      mem_write_d  = 1'b0;
      mem_to_reg_d = 1'b0;
    end else if (!stall_i) begin
      valid_d      = 1'b1;
      rs_data_d    = id_rs_data_i;
      rt_data_d    = id_rt_data_i;
      imm_d        = id_imm_i;
      rs_d         = id_rs_i;
      rt_d         = id_rt_i;
      wr_reg_d     = id_reg_dst_i ? id_rd_i : id_rt_i;
      alu_ctrl_d   = id_alu_ctrl_i;
      alu_src_d    = id_alu_src_i;
      reg_write_d  = id_reg_write_i;
      mem_read_d   = id_mem_read_i;
      mem_write_d  = id_mem_write_i;
      mem_to_reg_d = id_mem_to_reg_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q      <= 1'b0;
      rs_data_q    <= '0;
      rt_data_q    <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      wr_reg_q     <= '0;
      alu_ctrl_q   <= '0;
      alu_src_q    <= 1'b0;
      reg_write_q  <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      rs_data_q    <= rs_data_d;
      rt_data_q    <= rt_data_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      wr_reg_q     <= wr_reg_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      reg_write_q  <= reg_write_d;
      mem_read_q   <= mem_read_d;
      mem_write_q  <= mem_write_d;
      mem_to_reg_q <= mem_to_reg_d;
    end
  end

  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              id_hits_ex;

  // Register 0 is hardwired zero, so a write "to" it never creates a hazard.
  assign id_hits_ex = (wr_reg_q != '0) && id_valid_i &&
                      ((wr_reg_q == id_rs_i) || (wr_reg_q == id_rt_i));

`ifdef FORWARDING_EN
  // MEM is the younger producer, so it is checked before WB.
  always_comb begin
    opnd_a = rs_data_q;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rs_q))
      opnd_a = mem_result_i;
    else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rs_q))
      opnd_a = wb_result_i;

    opnd_b = rt_data_q;
    if (mem_reg_write_i && (mem_rd_i != '0) && (mem_rd_i == rt_q))
      opnd_b = mem_result_i;
    else if (wb_reg_write_i && (wb_rd_i != '0) && (wb_rd_i == rt_q))
      opnd_b = wb_result_i;
  end

  // Only a load in EX cannot be covered by forwarding.
  assign load_use_o = valid_q && mem_read_q && id_hits_ex;
`else
  logic id_hits_mem;
  logic unused_fwd_inputs;

  assign opnd_a = rs_data_q;
  assign opnd_b = rt_data_q;

  assign id_hits_mem = mem_reg_write_i && (mem_rd_i != '0) && id_valid_i &&
                       ((mem_rd_i == id_rs_i) || (mem_rd_i == id_rt_i));

  // Without forwarding every pending write in EX or MEM must be waited out;
  // WB is covered by the write-before-read register file.
  assign load_use_o = (valid_q && reg_write_q && id_hits_ex) || id_hits_mem;

  // Values and indices that only the forwarding muxes would consume.
  assign unused_fwd_inputs = ^{mem_result_i, wb_reg_write_i, wb_rd_i,
                               wb_result_i, rs_q, rt_q};
`endif

  assign alu_src1_o      = opnd_a;
  assign alu_src2_o      = alu_src_q ? imm_q : opnd_b;
  assign ex_store_data_o = opnd_b;
  assign alu_ctrl_o      = alu_ctrl_q;
  assign ex_wr_reg_o     = wr_reg_q;
  assign ex_valid_o      = valid_q;
  assign ex_reg_write_o  = reg_write_q;
  assign ex_mem_read_o   = mem_read_q;
  assign ex_mem_write_o  = mem_write_q;
  assign ex_mem_to_reg_o = mem_to_reg_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage. Expected EX-side results are queued when an ID
// instruction is driven and compared once the stage presents them.
module tb_id_ex_stage;

`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_rs_data_i, id_rt_data_i, id_imm_i;
  logic [4:0]  id_rs_i, id_rt_i, id_rd_i;
  logic [3:0]  id_alu_ctrl_i;
  logic        id_alu_src_i, id_reg_dst_i, id_reg_write_i;
  logic        id_mem_read_i, id_mem_write_i, id_mem_to_reg_i;
  logic        stall_i, flush_i;
  logic        mem_reg_write_i, wb_reg_write_i;
  logic [4:0]  mem_rd_i, wb_rd_i;
  logic [31:0] mem_result_i, wb_result_i;
  logic [31:0] alu_src1_o, alu_src2_o, ex_store_data_o;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  ex_wr_reg_o;
  logic        ex_valid_o, ex_reg_write_o, ex_mem_read_o, ex_mem_write_o;
  logic        ex_mem_to_reg_o, load_use_o;

  id_ex_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i),
    .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i), .id_imm_i(id_imm_i),
    .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .id_rd_i(id_rd_i),
    .id_alu_ctrl_i(id_alu_ctrl_i), .id_alu_src_i(id_alu_src_i),
    .id_reg_dst_i(id_reg_dst_i), .id_reg_write_i(id_reg_write_i),
    .id_mem_read_i(id_mem_read_i), .id_mem_write_i(id_mem_write_i),
    .id_mem_to_reg_i(id_mem_to_reg_i), .stall_i(stall_i), .flush_i(flush_i),
    .mem_reg_write_i(mem_reg_write_i), .mem_rd_i(mem_rd_i), .mem_result_i(mem_result_i),
    .wb_reg_write_i(wb_reg_write_i), .wb_rd_i(wb_rd_i), .wb_result_i(wb_result_i),
    .alu_src1_o(alu_src1_o), .alu_src2_o(alu_src2_o), .alu_ctrl_o(alu_ctrl_o),
    .ex_store_data_o(ex_store_data_o), .ex_wr_reg_o(ex_wr_reg_o),
    .ex_valid_o(ex_valid_o), .ex_reg_write_o(ex_reg_write_o),
    .ex_mem_read_o(ex_mem_read_o), .ex_mem_write_o(ex_mem_write_o),
    .ex_mem_to_reg_o(ex_mem_to_reg_o), .load_use_o(load_use_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [31:0] src1, src2, store;
    logic [3:0]  ctrl;
    logic [4:0]  wr;
    logic        valid, rw, mr, mw, m2r;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  exp_t bubble_e = '0;
  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, act, expv);
    end
  endtask

  // Pop the oldest expectation and compare every EX-side output against it.
  task automatic compare_front(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    check({tag, "_src1"},  alu_src1_o, e.src1);
    check({tag, "_src2"},  alu_src2_o, e.src2);
    check({tag, "_store"}, ex_store_data_o, e.store);
    check({tag, "_ctrl"},  {28'd0, alu_ctrl_o}, {28'd0, e.ctrl});
    check({tag, "_wr"},    {27'd0, ex_wr_reg_o}, {27'd0, e.wr});
    check({tag, "_ctl"},   {27'd0, ex_valid_o, ex_reg_write_o, ex_mem_read_o,
                            ex_mem_write_o, ex_mem_to_reg_o},
                           {27'd0, e.valid, e.rw, e.mr, e.mw, e.m2r});
    $display("txn %s: src1=%h src2=%h store=%h ctrl=%h wr=%0d valid=%b",
             tag, alu_src1_o, alu_src2_o, ex_store_data_o, alu_ctrl_o, ex_wr_reg_o, ex_valid_o);
  endtask

  // Advance one edge, expecting e to appear on the EX side.
  task automatic cycle(input string tag, input exp_t e);
    sb.push_back(e);
    @(posedge clk_i);
    #1;
    last_e = e;
    compare_front(tag);
  endtask

  // Drive an ID instruction with MEM/WB idle and return the expected EX view.
  task automatic drive_id(input logic v, input logic [31:0] rsd, input logic [31:0] rtd,
                          input logic [31:0] imm, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [3:0] ctrl, input logic asrc,
                          input logic rdst, input logic rw, input logic mr, input logic mw,
                          input logic m2r, output exp_t e);
    id_valid_i = v; id_rs_data_i = rsd; id_rt_data_i = rtd; id_imm_i = imm;
    id_rs_i = rs; id_rt_i = rt; id_rd_i = rd; id_alu_ctrl_i = ctrl;
    id_alu_src_i = asrc; id_reg_dst_i = rdst; id_reg_write_i = rw;
    id_mem_read_i = mr; id_mem_write_i = mw; id_mem_to_reg_i = m2r;
    mem_reg_write_i = 1'b0; mem_rd_i = '0; mem_result_i = '0;
    wb_reg_write_i = 1'b0; wb_rd_i = '0; wb_result_i = '0;
    if (!v) e = '0;
    else begin
      e.src1 = rsd; e.src2 = asrc ? imm : rtd; e.store = rtd; e.ctrl = ctrl;
      e.wr = rdst ? rd : rt; e.valid = 1'b1; e.rw = rw; e.mr = mr; e.mw = mw; e.m2r = m2r;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [3:0] ops [5];
    ops[0] = 4'b0000; ops[1] = 4'b0001; ops[2] = 4'b0010; ops[3] = 4'b0110; ops[4] = 4'b0111;
    stall_i = 1'b0; flush_i = 1'b0;
    drive_id(1'b0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, e);
    rst_i = 1'b1;
    #1;
    sb.push_back(bubble_e);
    compare_front("reset");
    repeat (2) @(posedge clk_i);
    #2 rst_i = 1'b0;
    @(negedge clk_i);

    // Plain add: rs_data=5, rt_data=7, rd=3
    drive_id(1'b1, 32'd5, 32'd7, 32'd0, 5'd1, 5'd2, 5'd3, 4'b0010, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("add", e);

    // Assorted captures; iteration 2 is an empty ID slot and must bubble.
    for (int i = 0; i < 5; i++) begin
      drive_id(i != 2, $urandom, $urandom, $urandom, 5'($urandom), 5'($urandom),
               5'($urandom), ops[i], 1'($urandom), 1'($urandom), 1'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom), e);
      cycle($sformatf("rand%0d", i), e);
    end

    // Stall: new ID contents must not be taken; registered part holds.
    stall_i = 1'b1;
    drive_id(1'b1, 32'hDEAD0001, 32'hDEAD0002, 32'h3, 5'd9, 5'd10, 5'd11, 4'b0110,
             1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("stall1", last_e);
    id_valid_i = 1'b0;
    cycle("stall2", last_e);
    flush_i = 1'b1;
    cycle("stall_flush", bubble_e);
    stall_i = 1'b0; flush_i = 1'b0;

    // Asynchronous reset mid-cycle with reg_write set in EX.
    drive_id(1'b1, 32'h12, 32'h34, 32'h0, 5'd2, 5'd3, 5'd4, 4'b0001, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("pre_rst", e);
    id_valid_i = 1'b0;
    #2 rst_i = 1'b1;
    #1;
    sb.push_back(bubble_e);
    compare_front("async_rst");
    #1 rst_i = 1'b0;
    cycle("post_rst", bubble_e);

    // Forward priority on operand A.
    drive_id(1'b1, 32'hAA, 32'hBB, 32'h0, 5'd4, 5'd6, 5'd5, 4'b0010, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("fwd_cap", e);
    mem_reg_write_i = 1'b1; mem_rd_i = 5'd4; mem_result_i = 32'h11;
    wb_reg_write_i = 1'b1; wb_rd_i = 5'd4; wb_result_i = 32'h22;
    #1 check("fwd_mem_wins", alu_src1_o, FWD ? 32'h11 : 32'hAA);
    mem_reg_write_i = 1'b0;
    #1 check("fwd_wb", alu_src1_o, FWD ? 32'h22 : 32'hAA);
    check("fwd_b_untouched", alu_src2_o, 32'hBB);

    // Register 0 is never forwarded.
    drive_id(1'b1, 32'h33, 32'h44, 32'h0, 5'd0, 5'd1, 5'd5, 4'b0000, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("r0_cap", e);
    mem_reg_write_i = 1'b1; mem_rd_i = 5'd0; mem_result_i = 32'h11;
    #1 check("r0_no_fwd", alu_src1_o, 32'h33);

    // Immediate operand while rt is forwarded from WB into the store path.
    drive_id(1'b1, 32'h1, 32'h44, 32'hFFFFFFFC, 5'd1, 5'd7, 5'd0, 4'b0010, 1'b1, 1'b0,
             1'b0, 1'b0, 1'b1, 1'b0, e);
    cycle("sw_cap", e);
    wb_reg_write_i = 1'b1; wb_rd_i = 5'd7; wb_result_i = 32'h99;
    #1 check("imm_src2", alu_src2_o, 32'hFFFFFFFC);
    check("store_fwd", ex_store_data_o, FWD ? 32'h99 : 32'h44);

    // Load in EX (lw to r8), dependent instruction in ID.
    drive_id(1'b1, 32'h100, 32'h0, 32'h4, 5'd1, 5'd8, 5'd0, 4'b0010, 1'b1, 1'b0,
             1'b1, 1'b1, 1'b0, 1'b1, e);
    cycle("lw_cap", e);
    id_valid_i = 1'b1; id_rs_i = 5'd8; id_rt_i = 5'd2;
    #1 check("lu_rs", {31'd0, load_use_o}, 32'd1);
    id_valid_i = 1'b0;
    #1 check("lu_invalid_id", {31'd0, load_use_o}, 32'd0);
    id_valid_i = 1'b1;
    flush_i = 1'b1;
    cycle("lu_flush", bubble_e);
    flush_i = 1'b0;
    check("lu_after_flush", {31'd0, load_use_o}, 32'd0);

    // Non-load producer in EX (add to r9), ID reads r9 as rt.
    drive_id(1'b1, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd9, 4'b0010, 1'b0, 1'b1,
             1'b1, 1'b0, 1'b0, 1'b0, e);
    cycle("add9_cap", e);
    id_valid_i = 1'b1; id_rs_i = 5'd3; id_rt_i = 5'd9;
    #1 check("raw_ex", {31'd0, load_use_o}, FWD ? 32'd0 : 32'd1);
    id_rt_i = 5'd10; mem_reg_write_i = 1'b1; mem_rd_i = 5'd10;
    #1 check("raw_mem", {31'd0, load_use_o}, FWD ? 32'd0 : 32'd1);
    mem_reg_write_i = 1'b0;
    #1 check("raw_none", {31'd0, load_use_o}, 32'd0);

    // Producer writing r0 never raises a hazard.
    drive_id(1'b1, 32'h5, 32'h6, 32'h0, 5'd1, 5'd2, 5'd0, 4'b0010, 1'b0, 1'b1,
             1'b1, 1'b1, 1'b0, 1'b1, e);
    cycle("r0wr_cap", e);
    id_valid_i = 1'b1; id_rs_i = 5'd0; id_rt_i = 5'd0;
    mem_reg_write_i = 1'b1; mem_rd_i = 5'd0;
    #1 check("r0_no_hazard", {31'd0, load_use_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
